// File: rtl/and_gate_checker_pkg.sv
// Shared definitions for the AND-gate scoreboard: FSM state encodings,
// default counter width / run length, and the reference gate model.
package and_gate_checker_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int DEF_CNT_W       = 8;
   localparam int DEF_NUM_SAMPLES = 4;

   // Reference model of the gate under test: true when the observed output
   // agrees with a & b.
   function automatic logic gate_ok(input logic a, input logic b, input logic o);
      return o == (a & b);
   endfunction

endpackage

// File: rtl/and_gate_checker_sat_counter.sv
// Saturating up-counter used for the pass and fail tallies. It sticks at
// the all-ones value instead of wrapping, so a long run can never report
// a misleadingly small count.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear has priority over increment; increment stops at the top value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/and_gate_checker.sv
// Scoreboard sitting behind a two-input AND gate. Each valid {a,b,o}
// triple is checked against a & b; passes, fails and input-combination
// coverage are tallied until NUM_SAMPLES samples have been seen.
// Optional first-failure capture (ff_vld / ff_idx / ff_vec) is compiled in
// when AND_CHK_FIRST_FAIL_EN is defined.
module and_gate_checker
   import and_gate_checker_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             o,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [3:0]       cov,
   output logic             all_pass
`ifdef AND_CHK_FIRST_FAIL_EN
   ,
   output logic             ff_vld,
   output logic [CNT_W-1:0] ff_idx,
   output logic [2:0]       ff_vec
`endif
);

   state_t           state;
   logic [CNT_W-1:0] smp;
   logic             start_run;
   logic             accept;
   logic             match;
   logic             last_smp;

   // Decode of the current cycle: start is only honoured outside RUN, and
   // samples are only counted inside RUN, so a start+valid beat is dropped.
   always_comb begin
      start_run = start && ((state == S_IDLE) || (state == S_DONE));
      accept    = in_valid && (state == S_RUN);
      match     = gate_ok(a, b, o);
      last_smp  = (smp + 1'b1) == CNT_W'(NUM_SAMPLES);
   end

   sat_counter #(.W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_run),
      .inc   (accept && match),
      .count (pass_cnt)
   );

   sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_run),
      .inc   (accept && !match),
      .count (fail_cnt)
   );

   // Run-control FSM plus the sample counter and coverage map.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         smp   <= '0;
         cov   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start_run) begin
                  state <= S_RUN;
                  smp   <= '0;
                  cov   <= '0;
               end
            end
            S_RUN: begin
               if (accept) begin
                  smp          <= smp + 1'b1;
                  cov[{a, b}]  <= 1'b1;
                  if (last_smp) begin
                     state <= S_DONE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef AND_CHK_FIRST_FAIL_EN
   // Capture the index and vector of the first mismatch of each run.
   always_ff @(posedge clk) begin
      if (rst || start_run) begin
         ff_vld <= 1'b0;
         ff_idx <= '0;
         ff_vec <= '0;
      end else if (accept && !match && !ff_vld) begin
         ff_vld <= 1'b1;
         ff_idx <= smp;
         ff_vec <= {a, b, o};
      end
   end
`endif

   // Status outputs are decoded straight from registered state.
   always_comb begin
      busy     = (state == S_RUN);
      done     = (state == S_DONE);
      all_pass = done && (fail_cnt == '0) && (cov == 4'hF);
   end

endmodule

// File: tb/tb_and_gate_checker.sv
// Directed bench for and_gate_checker. A main instance (CNT_W=8, 4 samples)
// covers the functional scenarios; two narrow instances cover the
// saturation cases. All instances share the same input stimulus.
module tb_and_gate_checker;

   logic clk = 1'b0;
   logic rst, start, in_valid, a, b, o;

   logic       busy, done, all_pass;
   logic [7:0] pass_cnt, fail_cnt;
   logic [3:0] cov;

   logic       busy2, done2, all_pass2;
   logic [1:0] pass_cnt2, fail_cnt2;
   logic [3:0] cov2;

   logic       busy3, done3, all_pass3;
   logic [2:0] pass_cnt3, fail_cnt3;
   logic [3:0] cov3;

`ifdef AND_CHK_FIRST_FAIL_EN
   logic       ff_vld, ff_vld2, ff_vld3;
   logic [7:0] ff_idx;
   logic [1:0] ff_idx2;
   logic [2:0] ff_idx3;
   logic [2:0] ff_vec, ff_vec2, ff_vec3;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   and_gate_checker #(.CNT_W(8), .NUM_SAMPLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .o(o),
      .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .cov(cov), .all_pass(all_pass)
`ifdef AND_CHK_FIRST_FAIL_EN
      , .ff_vld(ff_vld), .ff_idx(ff_idx), .ff_vec(ff_vec)
`endif
   );

   and_gate_checker #(.CNT_W(2), .NUM_SAMPLES(3)) dut2 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .o(o),
      .busy(busy2), .done(done2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
      .cov(cov2), .all_pass(all_pass2)
`ifdef AND_CHK_FIRST_FAIL_EN
      , .ff_vld(ff_vld2), .ff_idx(ff_idx2), .ff_vec(ff_vec2)
`endif
   );

   and_gate_checker #(.CNT_W(3), .NUM_SAMPLES(7)) dut3 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .o(o),
      .busy(busy3), .done(done3), .pass_cnt(pass_cnt3), .fail_cnt(fail_cnt3),
      .cov(cov3), .all_pass(all_pass3)
`ifdef AND_CHK_FIRST_FAIL_EN
      , .ff_vld(ff_vld3), .ff_idx(ff_idx3), .ff_vec(ff_vec3)
`endif
   );

   // Drive one cycle of inputs at a falling edge; returns at the next
   // falling edge, where results of the rising edge in between are stable.
   task automatic applyStimulus(input logic r, input logic s, input logic v,
                                input logic ia, input logic ib, input logic io);
      rst = r; start = s; in_valid = v; a = ia; b = ib; o = io;
      @(negedge clk);
   endtask

   task automatic test_reset;
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      tests_run++;
      if ({busy, done, all_pass, pass_cnt, fail_cnt, cov} !== 23'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got busy=%b done=%b all_pass=%b pass=%0d fail=%0d cov=%h, want all zero",
                  busy, done, all_pass, pass_cnt, fail_cnt, cov);
      end
`ifdef AND_CHK_FIRST_FAIL_EN
      tests_run++;
      if ({ff_vld, ff_idx, ff_vec} !== 12'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ff: got vld=%b idx=%0d vec=%b, want 0", ff_vld, ff_idx, ff_vec);
      end
`endif
   endtask

   task automatic test_truth_table;
      applyStimulus(0, 1, 0, 0, 0, 0);
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL truth_start: got busy=%b done=%b, want 1 0", busy, done);
      end
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 1, 1);
      applyStimulus(0, 0, 1, 0, 1, 0);
      tests_run++;
      if (done !== 1'b0 || pass_cnt !== 8'd3) begin
         tests_failed++;
         $display("[TB] FAIL truth_after3: got done=%b pass=%0d, want 0 3", done, pass_cnt);
      end
      applyStimulus(0, 0, 1, 1, 0, 0);
      tests_run++;
      if (done !== 1'b1 || all_pass !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL truth_done: got done=%b all_pass=%b busy=%b, want 1 1 0", done, all_pass, busy);
      end
      tests_run++;
      if (pass_cnt !== 8'd4 || fail_cnt !== 8'd0 || cov !== 4'hF) begin
         tests_failed++;
         $display("[TB] FAIL truth_counts: got pass=%0d fail=%0d cov=%h, want 4 0 f", pass_cnt, fail_cnt, cov);
      end
      // Valid beats in DONE are ignored; results hold.
      applyStimulus(0, 0, 1, 1, 1, 0);
      tests_run++;
      if (fail_cnt !== 8'd0 || pass_cnt !== 8'd4 || done !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL truth_hold: got pass=%0d fail=%0d done=%b, want 4 0 1", pass_cnt, fail_cnt, done);
      end
   endtask

   task automatic test_mismatch;
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 1, 1);
      applyStimulus(0, 0, 1, 0, 1, 1);
      applyStimulus(0, 0, 1, 1, 0, 0);
      tests_run++;
      if (pass_cnt !== 8'd3 || fail_cnt !== 8'd1 || all_pass !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL mismatch_counts: got pass=%0d fail=%0d all_pass=%b done=%b, want 3 1 0 1",
                  pass_cnt, fail_cnt, all_pass, done);
      end
`ifdef AND_CHK_FIRST_FAIL_EN
      tests_run++;
      if (ff_vld !== 1'b1 || ff_idx !== 8'd2 || ff_vec !== 3'b011) begin
         tests_failed++;
         $display("[TB] FAIL mismatch_ff: got vld=%b idx=%0d vec=%b, want 1 2 011", ff_vld, ff_idx, ff_vec);
      end
`endif
   endtask

   task automatic test_gaps;
      applyStimulus(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 1, 1, 1);
         applyStimulus(0, 0, 0, 0, 1, 1);
      end
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b1 || pass_cnt !== 8'd3) begin
         tests_failed++;
         $display("[TB] FAIL gaps_early: got done=%b busy=%b pass=%0d, want 0 1 3", done, busy, pass_cnt);
      end
      applyStimulus(0, 0, 1, 1, 1, 1);
      tests_run++;
      if (done !== 1'b1 || cov !== 4'b1000 || all_pass !== 1'b0 || pass_cnt !== 8'd4) begin
         tests_failed++;
         $display("[TB] FAIL gaps_done: got done=%b cov=%b all_pass=%b pass=%0d, want 1 1000 0 4",
                  done, cov, all_pass, pass_cnt);
      end
   endtask

   task automatic test_saturation;
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, 0, 1, 1, 1, 0);
      end
      tests_run++;
      if (fail_cnt2 !== 2'd3 || done2 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL sat_w2: got fail=%0d done=%b, want 3 1", fail_cnt2, done2);
      end
      tests_run++;
      if (fail_cnt3 !== 3'd7 || done3 !== 1'b1 || pass_cnt3 !== 3'd0) begin
         tests_failed++;
         $display("[TB] FAIL sat_w3: got fail=%0d done=%b pass=%0d, want 7 1 0", fail_cnt3, done3, pass_cnt3);
      end
   endtask

   task automatic test_reset_mid_run;
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 1, 1);
      applyStimulus(0, 0, 1, 0, 1, 1);
      applyStimulus(1, 1, 1, 1, 1, 1);
      tests_run++;
      if ({busy, done, all_pass, pass_cnt, fail_cnt, cov} !== 23'd0) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset: got busy=%b done=%b all_pass=%b pass=%0d fail=%0d cov=%h, want all zero",
                  busy, done, all_pass, pass_cnt, fail_cnt, cov);
      end
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 1, 0);
      applyStimulus(0, 0, 1, 1, 0, 0);
      applyStimulus(0, 0, 1, 1, 1, 1);
      tests_run++;
      if (pass_cnt !== 8'd4 || fail_cnt !== 8'd0 || all_pass !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL mid_rerun: got pass=%0d fail=%0d all_pass=%b, want 4 0 1", pass_cnt, fail_cnt, all_pass);
      end
   endtask

   task automatic test_back_to_back;
      applyStimulus(0, 1, 1, 1, 1, 1);
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || cov !== 4'h0) begin
         tests_failed++;
         $display("[TB] FAIL restart_clear: got busy=%b done=%b pass=%0d fail=%0d cov=%h, want 1 0 0 0 0",
                  busy, done, pass_cnt, fail_cnt, cov);
      end
      applyStimulus(0, 1, 1, 0, 0, 1);
      tests_run++;
      if (fail_cnt !== 8'd1 || cov !== 4'b0001 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL restart_count: got fail=%0d cov=%b busy=%b, want 1 0001 1", fail_cnt, cov, busy);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; o = 1'b0;
      test_reset();
      test_truth_table();
      test_mismatch();
      test_gaps();
      test_saturation();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
